// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver.
// Contents: capture FSM state enum, synchronizer depth.
package i2s_pkg;

    // Flops per asynchronous pin synchronizer
    localparam int unsigned SYNC_STAGES = 2;

    // Capture FSM: waiting for a left-slot start, or inside a left/right slot
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage : i2s_pkg

// File: rtl/sample_fifo.sv
// Stereo-frame FIFO with a registered head word and registered valid flag.
// DEPTH must be a power of two and at least 2; pointers carry one extra bit
// so that full and empty are told apart.
// Ports:
//   clk, rst_n   clock, async active-low reset (FIFO empties)
//   push         write push_data this cycle (dropped when full without a pop)
//   push_data    frame to write
//   pop          consumer accepts the head (ignored while valid is low)
//   valid        head holds a frame
//   head         oldest frame
//   drop_c       combinational: the push this cycle is being dropped
module sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_next;

    // Full when indices match but the wrap bits differ
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full | do_pop);
    assign drop_c  = push & full & ~do_pop;
    assign wr_next = wr_ptr + (AW+1)'(do_push);
    assign rd_next = rd_ptr + (AW+1)'(do_pop);

    // Next head: bypass the incoming frame when it lands at the new read index
    always_comb begin
        head_next = mem[rd_next[AW-1:0]];
        if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_next = push_data;
        end
    end

    // Pointers and registered head/valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            valid  <= (wr_next != rd_next);
            head   <= (wr_next != rd_next) ? head_next : '0;
        end
    end

    // Storage array (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule : sample_fifo

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the codec bit clock on Clk, captures left/right
// words MSB first with the I2S one-bit delay, and buffers stereo frames.
// Ports:
//   Clk, Reset_n          system clock, async active-low reset
//   Enable                high = capture, low = return to IDLE (FIFO kept)
//   Sclk, Lrclk, Sdin     asynchronous codec pins
//   Out_valid/Out_ready   frame handshake at the FIFO head
//   Out_left, Out_right   head frame samples
//   Overrun, Slot_err     sticky flags, cleared by a Clr_flags pulse
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic              Sclk,
    input  logic              Lrclk,
    input  logic              Sdin,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Out_left,
    output logic [DATA_W-1:0] Out_right,
    output logic              Overrun,
    output logic              Slot_err,
    input  logic              Clr_flags
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned FR_W  = 2 * DATA_W;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sclk_d;
    logic                   bit_evt;
    logic                   lr_s;
    logic                   sd_s;
    logic                   lr_q;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] left_hold;
    logic [DATA_W-1:0] left_hold_next;
    logic              left_ok;
    logic              left_ok_next;
    logic              frame_done;
    logic              frame_done_next;
    logic              slot_err_set;
    logic              fifo_drop;
    logic [FR_W-1:0]   head;

    // Pin synchronizers plus the delayed Sclk used for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], Sclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], Lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], Sdin};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign bit_evt = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign lr_s    = lr_sync[SYNC_STAGES-1];
    assign sd_s    = sd_sync[SYNC_STAGES-1];

    // Word-select history; tracked even while disabled so a restart sees a true 1->0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lr_q <= 1'b1;
        end else if (bit_evt) begin
            lr_q <= lr_s;
        end
    end

    // FSM state and capture datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            left_hold  <= '0;
            left_ok    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            shift      <= shift_next;
            left_hold  <= left_hold_next;
            left_ok    <= left_ok_next;
            frame_done <= frame_done_next;
        end
    end

    // Next state, bit counting and word capture
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        shift_next      = shift;
        left_hold_next  = left_hold;
        left_ok_next    = left_ok;
        frame_done_next = 1'b0;
        slot_err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (bit_evt && !lr_s && lr_q) begin
                    state_next   = LEFT;
                    cnt_next     = '0;
                    left_ok_next = 1'b0;
                end
            end
            LEFT, RIGHT: begin
                if (bit_evt) begin
                    if (lr_s != lr_q) begin
                        // Change bit carries the previous slot's tail; restart the count
                        state_next = lr_s ? RIGHT : LEFT;
                        cnt_next   = '0;
                        if ((cnt != '0) && (cnt < CNT_W'(DATA_W))) begin
                            slot_err_set = 1'b1;
                        end
                        // A new left slot invalidates any held left word
                        if (state == RIGHT) begin
                            left_ok_next = 1'b0;
                        end
                    end else if (cnt < CNT_W'(DATA_W)) begin
                        cnt_next   = cnt + CNT_W'(1);
                        shift_next = {shift[DATA_W-2:0], sd_s};
                        if (cnt_next == CNT_W'(DATA_W)) begin
                            if (state == LEFT) begin
                                left_hold_next = shift_next;
                                left_ok_next   = 1'b1;
                            end else begin
                                frame_done_next = left_ok;
                            end
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Disable aborts the partial word
        if (!Enable) begin
            state_next      = IDLE;
            cnt_next        = '0;
            left_ok_next    = 1'b0;
            frame_done_next = 1'b0;
            slot_err_set    = 1'b0;
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Overrun  <= 1'b0;
            Slot_err <= 1'b0;
        end else begin
            Overrun  <= fifo_drop    | (Overrun  & ~Clr_flags);
            Slot_err <= slot_err_set | (Slot_err & ~Clr_flags);
        end
    end

    sample_fifo #(
        .WIDTH (FR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (frame_done),
        .push_data ({left_hold, shift}),
        .pop       (Out_ready),
        .valid     (Out_valid),
        .head      (head),
        .drop_c    (fifo_drop)
    );

    assign Out_left  = head[FR_W-1:DATA_W];
    assign Out_right = head[DATA_W-1:0];

endmodule : i2s_rx

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: codec-side serializer, table of frames plus
// hand-written alignment, overrun, short-slot, abort and full-FIFO sequences.
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int DW = 16;

    logic          Clk;
    logic          Reset_n;
    logic          Enable;
    logic          Sclk;
    logic          Lrclk;
    logic          Sdin;
    logic          Out_valid;
    logic          Out_ready;
    logic [DW-1:0] Out_left;
    logic [DW-1:0] Out_right;
    logic          Overrun;
    logic          Slot_err;
    logic          Clr_flags;

    i2s_rx #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Enable    (Enable),
        .Sclk      (Sclk),
        .Lrclk     (Lrclk),
        .Sdin      (Sdin),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_left  (Out_left),
        .Out_right (Out_right),
        .Overrun   (Overrun),
        .Slot_err  (Slot_err),
        .Clr_flags (Clr_flags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Handshake monitor: counts accepted frames and keeps the last one
    int            pop_cnt = 0;
    logic [DW-1:0] last_l  = '0;
    logic [DW-1:0] last_r  = '0;
    always @(posedge Clk) begin
        if (Reset_n && Out_valid && Out_ready) begin
            pop_cnt = pop_cnt + 1;
            last_l  = Out_left;
            last_r  = Out_right;
        end
    end

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            slot;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One codec bit: data changes with Sclk low, sampled on the Sclk rise.
    // With pp set, Out_ready pulses on the cycle the resulting push lands.
    task automatic send_bit(input logic lr, input logic sd, input logic pp);
        Sclk  = 1'b0;
        Lrclk = lr;
        Sdin  = sd;
        repeat (8) @(negedge Clk);
        Sclk = 1'b1;
        if (pp) begin
            repeat (3) @(negedge Clk);
            Out_ready = 1'b1;
            @(negedge Clk);
            Out_ready = 1'b0;
            repeat (4) @(negedge Clk);
        end else begin
            repeat (8) @(negedge Clk);
        end
    endtask

    // Bit 0 is the change bit; bits 1..DW carry the word MSB first
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nbits, input logic pp);
        for (int i = 0; i < nbits; i++) begin
            logic sd;
            sd = (i >= 1 && i <= DW) ? w[DW-i] : 1'b0;
            send_bit(lr, sd, pp && (i == DW));
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbits, input logic pp);
        send_slot(1'b0, l, nbits, 1'b0);
        send_slot(1'b1, r, nbits, pp);
    endtask

    task automatic pop_check(input string name, input logic [DW-1:0] el, input logic [DW-1:0] er);
        check({name, " valid"}, 32'(Out_valid), 32'd1);
        check({name, " left"},  32'(Out_left),  32'(el));
        check({name, " right"}, 32'(Out_right), 32'(er));
        Out_ready = 1'b1;
        @(negedge Clk);
        Out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        Clr_flags = 1'b1;
        @(negedge Clk);
        Clr_flags = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        vecs[0] = '{16'hA5C3, 16'h1234, 32, 16'hA5C3, 16'h1234};
        vecs[1] = '{16'h8000, 16'h7FFF, 32, 16'h8000, 16'h7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 17, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'h0001, 16'hFFFE, 24, 16'h0001, 16'hFFFE};
        vecs[4] = '{16'h5A5A, 16'hC3C3, 64, 16'h5A5A, 16'hC3C3};

        Reset_n = 1'b0; Enable = 1'b0; Sclk = 1'b0; Lrclk = 1'b1;
        Sdin = 1'b0; Out_ready = 1'b0; Clr_flags = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst valid",    32'(Out_valid), 32'd0);
        check("rst left",     32'(Out_left),  32'd0);
        check("rst right",    32'(Out_right), 32'd0);
        check("rst overrun",  32'(Overrun),   32'd0);
        check("rst slot_err", 32'(Slot_err),  32'd0);
        Reset_n = 1'b1;
        Enable  = 1'b1;
        @(negedge Clk);

        // Alignment: join mid right slot, nothing until a full left+right pair
        send_slot(1'b1, 16'hFFFF, 12, 1'b0);
        check("align mid-right", 32'(Out_valid), 32'd0);
        send_slot(1'b0, 16'h1357, 32, 1'b0);
        check("align left only", 32'(Out_valid), 32'd0);
        send_slot(1'b1, 16'h2468, 32, 1'b0);
        pop_check("align frame", 16'h1357, 16'h2468);
        check("align drained", 32'(Out_valid), 32'd0);

        // Frame table
        foreach (vecs[i]) begin
            send_frame(vecs[i].l, vecs[i].r, vecs[i].slot, 1'b0);
            check($sformatf("vec%0d slot_err", i), 32'(Slot_err), 32'd0);
            pop_check($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
        end

        // Basic frame with the consumer always ready
        base = pop_cnt;
        Out_ready = 1'b1;
        send_frame(16'hA5C3, 16'h1234, 32, 1'b0);
        Out_ready = 1'b0;
        check("ready-hi count", 32'(pop_cnt - base), 32'd1);
        check("ready-hi left",  32'(last_l), 32'hA5C3);
        check("ready-hi right", 32'(last_r), 32'h1234);
        check("ready-hi empty", 32'(Out_valid), 32'd0);

        // Overrun: five frames into a four-deep FIFO
        for (int k = 0; k < 4; k++) send_frame(16'h1100 + 16'(k), 16'h2200 + 16'(k), 32, 1'b0);
        check("ovr before", 32'(Overrun), 32'd0);
        send_frame(16'h1104, 16'h2204, 32, 1'b0);
        check("ovr set", 32'(Overrun), 32'd1);
        for (int k = 0; k < 4; k++) pop_check($sformatf("ovr drain%0d", k), 16'h1100 + 16'(k), 16'h2200 + 16'(k));
        check("ovr empty",  32'(Out_valid), 32'd0);
        check("ovr sticky", 32'(Overrun),   32'd1);
        pulse_clr();
        check("ovr cleared", 32'(Overrun), 32'd0);

        // Full FIFO with a pop landing on the push cycle
        for (int k = 0; k < 4; k++) send_frame(16'h6100 + 16'(k), 16'h7200 + 16'(k), 32, 1'b0);
        send_frame(16'h6104, 16'h7204, 32, 1'b1);
        check("fullpp overrun", 32'(Overrun), 32'd0);
        for (int k = 1; k < 5; k++) pop_check($sformatf("fullpp drain%0d", k), 16'h6100 + 16'(k), 16'h7200 + 16'(k));
        check("fullpp empty", 32'(Out_valid), 32'd0);

        // Short left slot: error, no push; clear; next frame is clean
        send_slot(1'b0, 16'hFFFF, 8, 1'b0);
        send_slot(1'b1, 16'h4321, 32, 1'b0);
        check("short err",     32'(Slot_err),  32'd1);
        check("short no push", 32'(Out_valid), 32'd0);
        pulse_clr();
        check("short cleared", 32'(Slot_err), 32'd0);
        send_frame(16'h0F0F, 16'hF0F0, 32, 1'b0);
        check("short after err", 32'(Slot_err), 32'd0);
        pop_check("short after", 16'h0F0F, 16'hF0F0);

        // Reset after five left bits, with a frame buffered
        send_frame(16'hBEEF, 16'hCAFE, 32, 1'b0);
        send_slot(1'b0, 16'h1234, 6, 1'b0);
        Reset_n = 1'b0;
        Sclk    = 1'b0;
        Lrclk   = 1'b1;
        repeat (2) @(negedge Clk);
        check("midrst valid",    32'(Out_valid), 32'd0);
        check("midrst left",     32'(Out_left),  32'd0);
        check("midrst right",    32'(Out_right), 32'd0);
        check("midrst overrun",  32'(Overrun),   32'd0);
        check("midrst slot_err", 32'(Slot_err),  32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        send_slot(1'b1, 16'h0000, 32, 1'b0);
        send_frame(16'h3C3C, 16'hC3C3, 32, 1'b0);
        pop_check("midrst next", 16'h3C3C, 16'hC3C3);
        check("midrst empty", 32'(Out_valid), 32'd0);

        // Enable low after five left bits: FIFO kept, partial word dropped
        send_frame(16'hBEEF, 16'hCAFE, 32, 1'b0);
        send_slot(1'b0, 16'h1234, 6, 1'b0);
        Enable = 1'b0;
        repeat (3) @(negedge Clk);
        check("dis kept valid", 32'(Out_valid), 32'd1);
        check("dis kept left",  32'(Out_left),  32'hBEEF);
        Enable = 1'b1;
        send_slot(1'b1, 16'h0000, 32, 1'b0);
        send_frame(16'h6D6D, 16'h9292, 32, 1'b0);
        pop_check("dis old", 16'hBEEF, 16'hCAFE);
        pop_check("dis new", 16'h6D6D, 16'h9292);
        check("dis empty",    32'(Out_valid), 32'd0);
        check("dis slot_err", 32'(Slot_err),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2s_rx
